// File: rtl/mole_hit_scorer_if.sv
// Player/randomiser bus of the whack-a-mole scorer.
// The DUT side uses slave; the stimulus side uses master.
interface mole_hit_scorer_if #(
  parameter int N_MOLES = 18,
  parameter int SCORE_W = 10
);
  logic               start;
  logic               tick;
  logic [N_MOLES-1:0] moles;
  logic [N_MOLES-1:0] sw;
  logic               enable;
  logic [1:0]         level;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] misses;
  logic [6:0]         time_left;
  logic               game_over;

  modport master (
    output start, tick, moles, sw,
    input  enable, level, score, misses,
    input  time_left, game_over
  );

  modport slave (
    input  start, tick, moles, sw,
    output enable, level, score, misses,
    output time_left, game_over
  );
endinterface

// File: rtl/mole_hit_scorer.sv
// Whack-a-mole scorer: hits/misses, round timer,
// randomiser enable and score-driven difficulty level.
module mole_hit_scorer #(
  parameter int N_MOLES      = 18,
  parameter int SCORE_W      = 10,
  parameter int LEVEL_STEP   = 10,
  parameter int GAME_SECONDS = 60
) (
  input  logic             clk,
  input  logic             reset,
  mole_hit_scorer_if.slave bus
);

  localparam int         CW = $clog2(N_MOLES + 1);
  localparam logic [6:0] T0 = 7'(GAME_SECONDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [N_MOLES-1:0] sw_q;
  logic [N_MOLES-1:0] hit_mask, hit_mask_nxt;
  logic [N_MOLES-1:0] whack, hit, miss;
  logic [SCORE_W-1:0] score, score_nxt;
  logic [SCORE_W-1:0] misses, misses_nxt;
  logic [1:0]         level, level_nxt;
  logic [6:0]         time_left, time_nxt;
  logic               enable, game_over;

  function automatic logic [CW-1:0] popcnt(
    input logic [N_MOLES-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_MOLES; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(
    input logic [SCORE_W-1:0] a,
    input logic [CW-1:0]      b
  );
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W + 1)'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  function automatic logic [1:0] lvl_of(
    input logic [SCORE_W-1:0] s
  );
    if (int'(s) >= 3 * LEVEL_STEP)      return 2'd3;
    else if (int'(s) >= 2 * LEVEL_STEP) return 2'd2;
    else if (int'(s) >= LEVEL_STEP)     return 2'd1;
    else                                return 2'd0;
  endfunction

  // Edge detector is free-running so switch moves outside a round are absorbed.
  always_ff @(posedge clk)
    sw_q <= bus.sw;

  assign whack = (state == PLAY) ? (bus.sw ^ sw_q) : '0;
  assign hit   = whack & bus.moles & ~hit_mask;
  assign miss  = whack & ~bus.moles;

  always_comb begin
    state_nxt    = state;
    score_nxt    = score;
    misses_nxt   = misses;
    level_nxt    = level;
    time_nxt     = time_left;
    hit_mask_nxt = hit_mask & bus.moles;
    unique case (state)
      IDLE, OVER: begin
        if (bus.start) begin
          state_nxt    = PLAY;
          score_nxt    = '0;
          misses_nxt   = '0;
          level_nxt    = 2'd0;
          time_nxt     = T0;
          hit_mask_nxt = '0;
        end
      end
      PLAY: begin
        hit_mask_nxt = (hit_mask | hit) & bus.moles;
        score_nxt    = sat_add(score, popcnt(hit));
        misses_nxt   = sat_add(misses, popcnt(miss));
        level_nxt    = lvl_of(score);
        if (bus.tick) begin
          time_nxt = time_left - 7'd1;
          if (time_left == 7'd1)
            state_nxt = OVER;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      hit_mask  <= '0;
      score     <= '0;
      misses    <= '0;
      level     <= 2'd0;
      time_left <= 7'd0;
      enable    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      hit_mask  <= hit_mask_nxt;
      score     <= score_nxt;
      misses    <= misses_nxt;
      level     <= level_nxt;
      time_left <= time_nxt;
      enable    <= (state_nxt == PLAY);
      game_over <= (state_nxt == OVER);
    end
  end

  assign bus.enable    = enable;
  assign bus.level     = level;
  assign bus.score     = score;
  assign bus.misses    = misses;
  assign bus.time_left = time_left;
  assign bus.game_over = game_over;

endmodule
